// File: rtl/fetch_stage_pkg.sv
// Shared constants, IF_ID_BUS field layout and FSM encoding for the fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC   = 32'hBFC0_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'hBFC0_0380;

    localparam int unsigned INS_MSB = 61;
    localparam int unsigned INS_LSB = 30;
    localparam int unsigned PC_MSB  = 29;

    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2,
        StDrop = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_mux.sv
// Priority select of the redirect target: exception > ERET > branch/jump.
module fetch_redirect_mux
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic        br_valid,
    input  logic [29:0] br_target,
    input  logic [31:0] epc,
    output logic        kill,
    output logic [29:0] redirect_pc,
    output logic        eret_adel
);

    always_comb begin
        kill        = exc_valid | eret_valid | br_valid;
        redirect_pc = '0;
        eret_adel   = 1'b0;
        if (exc_valid) begin
            redirect_pc = EXC_VECTOR[31:2];
        end else if (eret_valid) begin
            redirect_pc = epc[31:2];
            eret_adel   = (epc[1:0] != 2'b00);
        end else if (br_valid) begin
            redirect_pc = br_target;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches one word at a time over req/ack/rvalid and
// holds {ins, pc} for DECODE until it is accepted or killed by a redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic        inst_rvalid,
    input  logic [31:0] inst_rdata,
    input  logic        id_allowin,
    output logic [61:0] IF_ID_BUS,
    output logic        if_valid,
    input  logic        br_valid,
    input  logic [29:0] br_target,
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    output logic        if_adel,
    output logic [31:0] if_badvaddr
);

    fetch_state_e state_q, state_d;
    logic [29:0]  pc_q, pc_d;
    logic [61:0]  bus_q, bus_d;
    logic         valid_q, valid_d;
    logic         adel_q, adel_d;
    logic [31:0]  badv_q, badv_d;
    logic         drop_q, drop_d;
    logic         kill, eret_adel, rvalid_live;
    logic [29:0]  redirect_pc;

    fetch_redirect_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_redirect_mux (
        .exc_valid   (exc_valid),
        .eret_valid  (eret_valid),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .epc         (epc),
        .kill        (kill),
        .redirect_pc (redirect_pc),
        .eret_adel   (eret_adel)
    );

    // drop_q marks one stale response still in flight; no new request until it lands.
    assign inst_req    = (state_q == StReq) && !drop_q && !reset;
    assign inst_addr   = {pc_q, 2'b00};
    assign rvalid_live = inst_rvalid && !drop_q;
    assign IF_ID_BUS   = bus_q;
    assign if_valid    = valid_q;
    assign if_adel     = adel_q;
    assign if_badvaddr = badv_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        bus_d   = bus_q;
        valid_d = valid_q;
        adel_d  = adel_q;
        badv_d  = badv_q;
        drop_d  = drop_q && !inst_rvalid;

        if (kill) begin
            valid_d = 1'b0;
            adel_d  = 1'b0;
            badv_d  = '0;
            pc_d    = redirect_pc;
            case (state_q)
                StReq:   state_d = (inst_req && inst_ack) ? StDrop : StReq;
                StWait:  state_d = rvalid_live ? StReq : StDrop;
                StHold:  state_d = StReq;
                default: state_d = rvalid_live ? StReq : StDrop;
            endcase
            // Misaligned ERET parks an address error in HOLD; any in-flight fetch is discarded.
            if (eret_adel) begin
                if (state_d == StDrop) drop_d = 1'b1;
                state_d = StHold;
                valid_d = 1'b1;
                adel_d  = 1'b1;
                badv_d  = epc;
                bus_d   = {32'b0, epc[31:2]};
            end
        end else begin
            case (state_q)
                StReq: begin
                    if (inst_req && inst_ack) state_d = StWait;
                end
                StWait: begin
                    if (rvalid_live) begin
                        bus_d   = {inst_rdata, pc_q};
                        valid_d = 1'b1;
                        pc_d    = pc_q + 30'd1;
                        state_d = StHold;
                    end
                end
                StHold: begin
                    // An address error stays put until an exception redirects the stage.
                    if (id_allowin && !adel_q) begin
                        valid_d = 1'b0;
                        state_d = StReq;
                    end
                end
                default: begin
                    if (rvalid_live) state_d = StReq;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StReq;
            pc_q    <= RESET_PC[31:2];
            bus_q   <= '0;
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
            badv_q  <= '0;
            drop_q  <= (drop_q || state_q == StWait || state_q == StDrop) && !inst_rvalid;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            bus_q   <= bus_d;
            valid_q <= valid_d;
            adel_q  <= adel_d;
            badv_q  <= badv_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        id_allowin;
    logic [61:0] IF_ID_BUS;
    logic        if_valid;
    logic        br_valid;
    logic [29:0] br_target;
    logic        exc_valid;
    logic        eret_valid;
    logic [31:0] epc;
    logic        if_adel;
    logic [31:0] if_badvaddr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_ack    (inst_ack),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .id_allowin  (id_allowin),
        .IF_ID_BUS   (IF_ID_BUS),
        .if_valid    (if_valid),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .exc_valid   (exc_valid),
        .eret_valid  (eret_valid),
        .epc         (epc),
        .if_adel     (if_adel),
        .if_badvaddr (if_badvaddr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request accepted immediately, data returned the following cycle.
    task automatic fetch_word(input logic [31:0] data);
        inst_ack = 1'b1;
        tick();
        inst_ack    = 1'b0;
        inst_rvalid = 1'b1;
        inst_rdata  = data;
        tick();
        inst_rvalid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; inst_ack = 1'b0; inst_rvalid = 1'b0; inst_rdata = '0;
        id_allowin = 1'b0; br_valid = 1'b0; br_target = '0; exc_valid = 1'b0;
        eret_valid = 1'b0; epc = '0;
        tick();
        tick();
        check("rst_req", 64'(inst_req), 64'd0);
        check("rst_valid", 64'(if_valid), 64'd0);
        check("rst_bus", 64'(IF_ID_BUS), 64'd0);
        check("rst_adel", 64'(if_adel), 64'd0);
        check("rst_badv", 64'(if_badvaddr), 64'd0);
        reset = 1'b0;
        #1;
        check("first_req", 64'(inst_req), 64'd1);
        check("first_addr", 64'(inst_addr), 64'hBFC00000);

        // Basic fetch and handoff
        inst_ack = 1'b1;
        tick();
        inst_ack = 1'b0; inst_rvalid = 1'b1; inst_rdata = 32'h24010001;
        check("wait_req", 64'(inst_req), 64'd0);
        tick();
        inst_rvalid = 1'b0;
        check("hold_valid", 64'(if_valid), 64'd1);
        check("hold_bus", 64'(IF_ID_BUS), 64'({32'h24010001, 30'h2FF00000}));
        id_allowin = 1'b1;
        tick();
        id_allowin = 1'b0;
        check("handoff_valid", 64'(if_valid), 64'd0);
        check("second_addr", 64'(inst_addr), 64'hBFC00004);

        // Decode stall for 5 cycles
        fetch_word(32'h8C220004);
        for (int i = 0; i < 5; i++) begin
            check("stall_bus", 64'(IF_ID_BUS), 64'({32'h8C220004, 30'h2FF00001}));
            check("stall_req", 64'(inst_req), 64'd0);
            tick();
        end
        id_allowin = 1'b1;
        tick();
        id_allowin = 1'b0;
        check("post_stall_addr", 64'(inst_addr), 64'hBFC00008);

        // Branch in WAIT, response arrives two cycles later
        inst_ack = 1'b1;
        tick();
        inst_ack = 1'b0; br_valid = 1'b1; br_target = 30'h00000100;
        tick();
        br_valid = 1'b0;
        check("drop_req", 64'(inst_req), 64'd0);
        tick();
        inst_rvalid = 1'b1; inst_rdata = 32'hDEADBEEF;
        tick();
        inst_rvalid = 1'b0;
        check("br_killed_valid", 64'(if_valid), 64'd0);
        check("br_addr", 64'(inst_addr), 64'h00000400);
        check("br_req", 64'(inst_req), 64'd1);

        // Exception beats branch in the same cycle
        exc_valid = 1'b1; br_valid = 1'b1; br_target = 30'h00000055;
        tick();
        exc_valid = 1'b0; br_valid = 1'b0;
        check("exc_addr", 64'(inst_addr), 64'hBFC00380);

        // Ack and redirect together: ack honoured, response discarded
        inst_ack = 1'b1; br_valid = 1'b1; br_target = 30'h00000200;
        tick();
        inst_ack = 1'b0; br_valid = 1'b0;
        check("ackbr_req", 64'(inst_req), 64'd0);
        inst_rvalid = 1'b1; inst_rdata = 32'h12345678;
        tick();
        inst_rvalid = 1'b0;
        check("ackbr_valid", 64'(if_valid), 64'd0);
        check("ackbr_addr", 64'(inst_addr), 64'h00000800);

        // PC wraps from the top word to zero
        br_valid = 1'b1; br_target = 30'h3FFFFFFF;
        tick();
        br_valid = 1'b0;
        check("top_addr", 64'(inst_addr), 64'hFFFFFFFC);
        fetch_word(32'h00000000);
        check("top_bus", 64'(IF_ID_BUS), 64'({32'h00000000, 30'h3FFFFFFF}));
        id_allowin = 1'b1;
        tick();
        id_allowin = 1'b0;
        check("wrap_addr", 64'(inst_addr), 64'h00000000);

        // Misaligned ERET while HOLD is being accepted: transfer cancelled
        fetch_word(32'h11111111);
        check("pre_eret_valid", 64'(if_valid), 64'd1);
        eret_valid = 1'b1; epc = 32'h80000002; id_allowin = 1'b1;
        tick();
        eret_valid = 1'b0;
        check("eret_valid", 64'(if_valid), 64'd1);
        check("eret_adel", 64'(if_adel), 64'd1);
        check("eret_badv", 64'(if_badvaddr), 64'h80000002);
        check("eret_bus", 64'(IF_ID_BUS), 64'({32'h0, 30'h20000000}));
        for (int i = 0; i < 3; i++) begin
            check("eret_noreq", 64'(inst_req), 64'd0);
            tick();
        end
        id_allowin = 1'b0;
        exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0;
        check("exc_clr_adel", 64'(if_adel), 64'd0);
        check("exc_clr_valid", 64'(if_valid), 64'd0);
        check("exc_clr_addr", 64'(inst_addr), 64'hBFC00380);

        // Reset while WAIT; stale response must be dropped
        inst_ack = 1'b1;
        tick();
        inst_ack = 1'b0; reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rstw_req", 64'(inst_req), 64'd0);
        tick();
        check("rstw_req2", 64'(inst_req), 64'd0);
        inst_rvalid = 1'b1; inst_rdata = 32'hBADBAD00;
        tick();
        inst_rvalid = 1'b0;
        check("rstw_valid", 64'(if_valid), 64'd0);
        check("rstw_req3", 64'(inst_req), 64'd1);
        check("rstw_addr", 64'(inst_addr), 64'hBFC00000);
        fetch_word(32'h24020002);
        check("rstw_bus", 64'(IF_ID_BUS), 64'({32'h24020002, 30'h2FF00000}));
        check("rstw_hold", 64'(if_valid), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline; sits directly upstream of DECODE.
- Owns the PC and issues word fetches to instruction memory over a req/ack/rvalid handshake.
- Delivers {instruction, pc} to DECODE on the 62-bit IF_ID_BUS, with a one-entry hold buffer for decode stalls.
- Accepts redirects from EXE (branch/jump), CP0 (exception) and ERET.

Parameters:
RESET_PC, 32'hBFC0_0000, byte address fetched first after reset
EXC_VECTOR, 32'hBFC0_0380, byte address fetched after an exception redirect

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_req  out  1  fetch request valid
inst_addr  out  32  fetch byte address, {pc,2'b00}
inst_ack  in  1  memory accepted request this cycle
inst_rvalid  in  1  read data valid; exactly one per accepted request, ≥1 cycle after ack
inst_rdata  in  32  instruction word
id_allowin  in  1  DECODE accepts IF_ID_BUS this cycle (DECODE "valid")
IF_ID_BUS  out  62  {ins[31:0], pc[29:0]}
if_valid  out  1  IF_ID_BUS holds a live instruction
br_valid  in  1  EXE branch/jump redirect
br_target  in  30  word address of branch target
exc_valid  in  1  CP0 exception redirect
eret_valid  in  1  ERET redirect
epc  in  32  ERET return byte address
if_adel  out  1  fetch address error; valid with if_valid
if_badvaddr  out  32  offending address when if_adel

Behaviour:
- Reset (any cycle, including mid-transaction): pc=RESET_PC[31:2]; state=REQ; if_valid=0; inst_req=0; if_adel=0; if_badvaddr=0; IF_ID_BUS=0. Any outstanding rvalid after reset is dropped (drop flag set if reset hits in WAIT).
- FSM states:
  - REQ: inst_req=1, inst_addr={pc,2'b00}. On inst_ack → WAIT.
  - WAIT: inst_req=0. On inst_rvalid, latch {inst_rdata,pc} into buffer; if_valid=1 next cycle; pc+=1 (30-bit wrap 3FFFFFFF→0). → HOLD.
  - HOLD: if_valid=1, bus stable. On id_allowin → REQ, with if_valid=0 next cycle. Otherwise stay.
  - DROP: inst_req=0; wait for rvalid, discard data → REQ.
- Throughput: one instruction per 3 cycles minimum (REQ-ack, rvalid, handoff). No speculative second request.
- Redirects are one-cycle pulses with priority exc_valid > eret_valid > br_valid. Next pc becomes EXC_VECTOR[31:2], epc[31:2] or br_target respectively.
  - Buffer/IF_ID_BUS contents are killed: if_valid=0 next cycle, even if id_allowin is set the same cycle (the transfer is cancelled).
  - Redirect in REQ without ack, or in HOLD → REQ at the new pc.
  - Redirect in REQ with ack, or in WAIT without rvalid → DROP.
  - Redirect in WAIT with rvalid: data discarded → REQ.
- EXE asserts br_valid only after the delay-slot instruction has been accepted by DECODE. The stage never reasons about delay slots itself.
- ERET with epc[1:0]≠0: no fetch issued. if_valid=1, if_adel=1, if_badvaddr=epc, IF_ID_BUS={32'b0, epc[31:2]}; state HOLD. A later exc_valid clears it.
- Simultaneous inst_ack and redirect: ack honoured, then DROP.
- pc increments only on accepted fetch data, never on a killed one.

Decomposition:
- Shared package: RESET_PC/EXC_VECTOR constants; IF_ID_BUS field offsets (INS_MSB=61, INS_LSB=30, PC_MSB=29); FSM state encoding (REQ=2'd0, WAIT=2'd1, HOLD=2'd2, DROP=2'd3).
- One natural sub-module, fetch_redirect_mux: combinational priority select of next pc and kill signal.

Test Plan:
- Reset, ack immediate, rvalid next cycle with 32'h24010001, id_allowin=1 → inst_addr=32'hBFC00000; IF_ID_BUS={32'h24010001,30'h2FF00000}; second request at 32'hBFC00004.
- id_allowin=0 for 5 cycles in HOLD → IF_ID_BUS stable, inst_req=0 throughout; on allowin, next request at pc+4.
- br_valid (target 30'h00000100) in WAIT, rvalid 2 cycles later → rvalid data never appears on the bus; next inst_addr=32'h00000400.
- exc_valid and br_valid in same cycle → next inst_addr=32'hBFC00380.
- eret_valid with epc=32'h80000002 → if_valid=1, if_adel=1, if_badvaddr=32'h80000002, no inst_req.
- reset asserted in WAIT, stale rvalid arrives after → dropped; first delivered pc=30'h2FF00000.
